// File: rtl/fixed_point_divider_seq_pkg.sv
// Shared widths, FSM encoding and operand-alignment helper for the
// fixed-point arithmetic blocks (word = {sf[2:0], mant[12:0]}).
package fixed_point_divider_seq_pkg;

  localparam int WORD_W   = 16;
  localparam int SF_W     = 3;
  localparam int MANT_W   = 13;
  localparam int DIV_ITER = 28;
  localparam int NUM_W    = DIV_ITER;
  localparam int ITER_W   = 5;
  localparam int SHIFT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Numerator pre-shift so that the raw quotient lands on scale max(sa, sb).
  function automatic logic [SHIFT_W-1:0] num_shift(input logic [SF_W-1:0] sa,
                                                    input logic [SF_W-1:0] sb);
    if (sa >= sb) begin
      return {1'b0, sb};
    end
    return {sb, 1'b0} - {1'b0, sa};
  endfunction

endpackage

// File: rtl/fixed_point_unpack.sv
// Splits a fixed-point word into scale factor, sign-extended mantissa,
// sign and magnitude. Magnitude is 13-bit unsigned so -4096 maps to 4096.
module fixed_point_unpack
  import fixed_point_divider_seq_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [SF_W-1:0]   sf,
  output logic [WORD_W-1:0] mant_ext,
  output logic              neg,
  output logic [MANT_W-1:0] mag
);

  // Pure field decode; no state.
  always_comb begin
    sf       = word[WORD_W-1:MANT_W];
    neg      = word[MANT_W-1];
    mant_ext = {{SF_W{word[MANT_W-1]}}, word[MANT_W-1:0]};
    mag      = word[MANT_W-1] ? (~word[MANT_W-1:0] + 1'b1) : word[MANT_W-1:0];
  end

endmodule

// File: rtl/fixed_point_divider_seq.sv
// Sequential fixed-point divider: one restoring-division step per cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; operands sampled on the start edge
// CALC    | 28 restoring steps, MSB first; iter_q counts down to 0
// DONE    | one-cycle done pulse; quotient/flags already registered
module fixed_point_divider_seq
  import fixed_point_divider_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] dividend,
  input  logic [WORD_W-1:0] divisor,
  output logic [WORD_W-1:0] quotient,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              div_by_zero
);

  logic [SF_W-1:0]   sf_a, sf_b;
  logic [WORD_W-1:0] ext_a, ext_b;
  logic              neg_a, neg_b;
  logic [MANT_W-1:0] mag_a, mag_b;

  fixed_point_unpack u_unpack_a (.word(dividend), .sf(sf_a), .mant_ext(ext_a), .neg(neg_a), .mag(mag_a));
  fixed_point_unpack u_unpack_b (.word(divisor),  .sf(sf_b), .mant_ext(ext_b), .neg(neg_b), .mag(mag_b));

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic [MANT_W-1:0] rem_q, rem_d;
  logic [MANT_W-1:0] den_q, den_d;
  logic              neg_q, neg_d;
  logic [SF_W-1:0]   sf_q, sf_d;
  logic [WORD_W-1:0] quo_q, quo_d;
  logic              ovf_q, ovf_d;
  logic              dbz_q, dbz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [SF_W-1:0]    sf_max;
  logic [SHIFT_W-1:0] k;
  logic [MANT_W:0]    trial, diff;
  logic               take;
  logic [MANT_W-1:0]  rem_step;
  logic [NUM_W-1:0]   num_step;
  logic [NUM_W:0]     s_full;
  logic               ovf_calc;

  // One restoring step plus signed result/overflow of the final step.
  always_comb begin
    sf_max   = (sf_a >= sf_b) ? sf_a : sf_b;
    k        = num_shift(sf_a, sf_b);
    trial    = {rem_q, num_q[NUM_W-1]};
    diff     = trial - {1'b0, den_q};
    take     = (trial >= {1'b0, den_q});
    rem_step = take ? diff[MANT_W-1:0] : trial[MANT_W-1:0];
    num_step = {num_q[NUM_W-2:0], take};
    s_full   = neg_q ? (~{1'b0, num_step} + 1'b1) : {1'b0, num_step};
    ovf_calc = neg_q ? (num_step > NUM_W'(4096)) : (num_step > NUM_W'(4095));
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    num_d   = num_q;
    rem_d   = rem_q;
    den_d   = den_q;
    neg_d   = neg_q;
    sf_d    = sf_q;
    quo_d   = quo_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sf_d  = sf_max;
          // A zero dividend gives a non-negative zero regardless of signs.
          neg_d = (neg_a ^ neg_b) & (ext_a != '0);
          num_d = NUM_W'(mag_a) << k;
          den_d = mag_b;
          rem_d = '0;
          if (ext_b == '0) begin
            state_d = ST_DONE;
            quo_d   = {sf_max, {MANT_W{1'b0}}};
            ovf_d   = 1'b0;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
            iter_d  = ITER_W'(DIV_ITER - 1);
          end
        end
      end
      ST_CALC: begin
        num_d = num_step;
        rem_d = rem_step;
        if (iter_q == '0) begin
          state_d = ST_DONE;
          quo_d   = {sf_q, s_full[MANT_W-1:0]};
          ovf_d   = ovf_calc;
          dbz_d   = 1'b0;
        end else begin
          iter_d = iter_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // All state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      neg_q   <= 1'b0;
      sf_q    <= '0;
      quo_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      neg_q   <= neg_d;
      sf_q    <= sf_d;
      quo_q   <= quo_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quotient    = quo_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fixed_point_divider_seq.sv
// Self-checking bench for fixed_point_divider_seq: vector table + scoreboard,
// random operands against a behavioural model, and hand-written corner cases.
module tb_fixed_point_divider_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend, divisor;
  logic [15:0] quotient;
  logic        busy, done, overflow, div_by_zero;

  fixed_point_divider_seq dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .busy(busy), .done(done), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        ov;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic        ov;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: exact integer arithmetic, truncation toward zero.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    int          sa, sb, ma, mb, k, sm;
    longint      n, q, s;
    logic [63:0] sv;
    logic [2:0]  sm3;
    sa  = int'(a[15:13]);
    sb  = int'(b[15:13]);
    ma  = $signed(a[12:0]);
    mb  = $signed(b[12:0]);
    sm  = (sa > sb) ? sa : sb;
    sm3 = 3'(sm);
    if (mb == 0) begin
      e.q = {sm3, 13'd0}; e.ov = 1'b0; e.dbz = 1'b1; e.lat = 0;
    end else begin
      k   = (sa >= sb) ? sb : (2 * sb - sa);
      n   = longint'((ma < 0) ? -ma : ma) << k;
      q   = n / longint'((mb < 0) ? -mb : mb);
      s   = ((ma < 0) != (mb < 0)) ? -q : q;
      sv  = s;
      e.q = {sm3, sv[12:0]};
      e.ov  = (s < -4096) || (s > 4095);
      e.dbz = 1'b0;
      e.lat = 28;
    end
    return e;
  endfunction

  function automatic exp_t from_vec(input vec_t v);
    exp_t e;
    e.q = v.q; e.ov = v.ov; e.dbz = v.dbz; e.lat = v.dbz ? 0 : 28;
    return e;
  endfunction

  // Drive one operation; expectation must already be on the scoreboard.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag);
    exp_t e;
    int   lat;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    if (!done) begin
      chk({tag, " done timeout"}, 32'(lat), 32'(e.lat));
      return;
    end
    chk({tag, " latency"}, 32'(lat), 32'(e.lat));
    chk({tag, " quotient"}, 32'(quotient), 32'(e.q));
    chk({tag, " overflow"}, 32'(overflow), 32'(e.ov));
    chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
    @(negedge clk);
    chk({tag, " done pulse width"}, 32'(done), 32'd0);
    chk({tag, " busy after"}, 32'(busy), 32'd0);
    chk({tag, " quotient held"}, 32'(quotient), 32'(e.q));
  endtask

  vec_t vecs[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   extra;
    exp_t e;

    vecs[0]  = '{16'h0006, 16'h0002, 16'h0003, 1'b0, 1'b0};
    vecs[1]  = '{16'h4006, 16'h2001, 16'h400C, 1'b0, 1'b0};
    vecs[2]  = '{16'h1FF9, 16'h0002, 16'h1FFD, 1'b0, 1'b0};
    vecs[3]  = '{16'h0005, 16'h2000, 16'h2000, 1'b0, 1'b1};
    vecs[4]  = '{16'h0FFF, 16'hE001, 16'hE000, 1'b1, 1'b0};
    vecs[5]  = '{16'h0000, 16'h0003, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{16'h0006, 16'h1FFE, 16'h1FFD, 1'b0, 1'b0};
    vecs[7]  = '{16'h1000, 16'h0001, 16'h1000, 1'b0, 1'b0};
    vecs[8]  = '{16'h1000, 16'h1FFF, 16'h1000, 1'b1, 1'b0};
    vecs[9]  = '{16'h0FFF, 16'h0001, 16'h0FFF, 1'b0, 1'b0};
    vecs[10] = '{16'h0003, 16'hE000, 16'hE000, 1'b0, 1'b1};
    vecs[11] = '{16'h2003, 16'h0002, 16'h2001, 1'b0, 1'b0};
    vecs[12] = '{16'h0001, 16'h6003, 16'h6015, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset quotient", 32'(quotient), 32'h0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      sb_q.push_back(from_vec(vecs[i]));
      run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      if (i == 3) rb[12:0] = 13'd0;
      sb_q.push_back(model(ra, rb));
      run_op(ra, rb, $sformatf("rnd%0d", i));
    end

    // start pulsed during CALC (with new operands) and during DONE: ignored.
    sb_q.push_back(model(16'h0006, 16'h0002));
    @(negedge clk);
    dividend = 16'h0006; divisor = 16'h0002; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    repeat (5) begin @(negedge clk); cyc++; end
    dividend = 16'h0FFF; divisor = 16'h0001; start = 1'b1;
    @(negedge clk); cyc++;
    start = 1'b0;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    e = sb_q.pop_front();
    chk("ignore latency", 32'(cyc), 32'(e.lat));
    chk("ignore quotient", 32'(quotient), 32'(e.q));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignore done width", 32'(done), 32'd0);
    chk("ignore busy idle", 32'(busy), 32'd0);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("ignore no second op", 32'(extra), 32'd0);

    // leave overflow set so the reset check below sees it cleared
    sb_q.push_back(from_vec(vecs[4]));
    run_op(16'h0FFF, 16'hE001, "pre-reset ovf");

    // reset asserted at CALC iteration 10
    @(negedge clk);
    dividend = 16'h0006; divisor = 16'h0002; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset quotient", 32'(quotient), 32'h0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset overflow", 32'(overflow), 32'd0);
    chk("midreset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("midreset no done", 32'(extra), 32'd0);

    sb_q.push_back(from_vec(vecs[0]));
    run_op(16'h0006, 16'h0002, "post-reset");

    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
